simple_dma_rd: RTL

Read-side counterpart of simple_dma. It takes buffer descriptors (start address and size, both in 128-bit word units) from software and issues Avalon-MM burst reads to SDRAM. Returned data is pushed into a downstream stream FIFO, and a done counter is published per completed buffer. It sits between the HPS SDRAM port and a playback/readback FIFO in the CLK_80 bus-clock domain.

---
 rtl/simple_dma_pkg.sv | 27 ++
 rtl/dma_cmd_fifo.sv | 49 ++++
 rtl/simple_dma_rd.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/simple_dma_pkg.sv
// Shared types for the simple_dma read engine:
// descriptor layout, FSM states, burst helper.
package simple_dma_pkg;

    localparam int DMA_ADDR_W = 28;
    localparam int BURST_W    = 8;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] adr;
        logic [DMA_ADDR_W-1:0] size;
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DRAIN
    } dma_state_e;

    function automatic logic [BURST_W-1:0] min_burst(
        input logic [DMA_ADDR_W-1:0] rem,
        input logic [BURST_W-1:0]    max_b
    );
        return (rem < DMA_ADDR_W'(max_b)) ? rem[BURST_W-1:0] : max_b;
    endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Descriptor FIFO: DEPTH entries of desc_t, extra-bit pointers
// for full/empty; head is visible combinationally.
module dma_cmd_fifo
    import simple_dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_push,
    input  desc_t i_din,
    input  logic  i_pop,
    output desc_t o_dout,
    output logic  o_full,
    output logic  o_empty
);

    localparam int PW = $clog2(DEPTH);

    desc_t          r_mem [DEPTH];
    logic  [PW:0]   r_wr_ptr;
    logic  [PW:0]   r_rd_ptr;
    logic           w_push;
    logic           w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/simple_dma_rd.sv
// Descriptor-driven Avalon-MM burst reader feeding a stream FIFO,
// with credit-based flow control against the FIFO free count.
module simple_dma_rd
    import simple_dma_pkg::*;
#(
    parameter int ADDR_W    = DMA_ADDR_W,
    parameter int DATA_W    = 128,
    parameter int BURST_MAX = 16,
    parameter int CMD_DEPTH = 4,
    parameter int FREE_W    = 13
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] START_ADR,
    input  logic [ADDR_W-1:0] BUF_SIZE,
    input  logic              START,
    output logic              CMD_FULL,
    output logic [15:0]       DONE_CNT,
    output logic              BUSY,
    output logic [ADDR_W-1:0] SDRAM_ADDRESS,
    output logic [7:0]        SDRAM_BURSTCOUNT,
    output logic              SDRAM_READ,
    input  logic              SDRAM_WAITREQUEST,
    input  logic [DATA_W-1:0] SDRAM_READDATA,
    input  logic              SDRAM_READDATAVALID,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_WR_EN,
    input  logic [FREE_W-1:0] OUT_FREE_CNT
);

    dma_state_e          r_state;
    dma_state_e          w_state_nxt;
    logic [ADDR_W-1:0]   r_cur_adr;
    logic [ADDR_W-1:0]   r_rem;
    logic [ADDR_W:0]     r_outst;
    logic [15:0]         r_done_cnt;
    logic                r_read;
    logic [ADDR_W-1:0]   r_addr;
    logic [BURST_W-1:0]  r_bc;
    logic                r_out_wr_en;
    logic [DATA_W-1:0]   r_out_data;

    desc_t               w_din;
    desc_t               w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_done_inc;
    logic                w_accept;
    logic                w_ret;
    logic [ADDR_W-1:0]   w_acc_len;
    logic [ADDR_W-1:0]   w_adr_nxt;
    logic [ADDR_W-1:0]   w_rem_nxt;
    logic [ADDR_W:0]     w_outst_nxt;
    logic [BURST_W-1:0]  w_blen;
    logic [ADDR_W+1:0]   w_need;
    logic                w_issue;
    logic                w_req_slot;

    assign w_din.adr  = DMA_ADDR_W'(START_ADR);
    assign w_din.size = DMA_ADDR_W'(BUF_SIZE);

    dma_cmd_fifo #(
        .DEPTH   (CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (START),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_accept    = r_read & ~SDRAM_WAITREQUEST;
    assign w_ret       = SDRAM_READDATAVALID & (r_outst != '0);
    assign w_acc_len   = w_accept ? ADDR_W'(r_bc) : '0;
    assign w_adr_nxt   = r_cur_adr + w_acc_len;
    assign w_rem_nxt   = r_rem - w_acc_len;
    assign w_outst_nxt = r_outst + (ADDR_W+1)'(w_acc_len)
                       - (ADDR_W+1)'(w_ret);
    assign w_blen      = min_burst(DMA_ADDR_W'(w_rem_nxt),
                                   BURST_W'(BURST_MAX));

    // A beat leaving via OUT this cycle is not yet reflected in the
    // free count, so it still holds a credit.
    assign w_need      = (ADDR_W+2)'(r_outst)
                       + (ADDR_W+2)'(w_acc_len)
                       + (ADDR_W+2)'(r_out_wr_en)
                       + (ADDR_W+2)'(w_blen);
    assign w_issue     = (w_rem_nxt != '0) &&
                         ((ADDR_W+2)'(OUT_FREE_CNT) >= w_need);
    assign w_req_slot  = (r_state == ST_ISSUE) && (!r_read || w_accept);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done_inc  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_pop = 1'b1;
                if (w_head.size == '0) begin
                    w_done_inc  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_rem_nxt == '0) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_outst == '0) begin
                    w_done_inc  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_cur_adr  <= '0;
            r_rem      <= '0;
            r_outst    <= '0;
            r_done_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= w_outst_nxt;
            if (w_done_inc) r_done_cnt <= r_done_cnt + 16'd1;
            if (r_state == ST_LOAD) begin
                r_cur_adr <= ADDR_W'(w_head.adr);
                r_rem     <= ADDR_W'(w_head.size);
            end else if (r_state == ST_ISSUE) begin
                r_cur_adr <= w_adr_nxt;
                r_rem     <= w_rem_nxt;
            end
        end
    end

    // Request registers only move when no request is pending,
    // which keeps them stable under waitrequest.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_read <= 1'b0;
            r_addr <= '0;
            r_bc   <= '0;
        end else if (w_req_slot) begin
            r_read <= w_issue;
            r_addr <= w_issue ? w_adr_nxt : '0;
            r_bc   <= w_issue ? w_blen : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_wr_en <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_wr_en <= w_ret;
            if (w_ret) r_out_data <= SDRAM_READDATA;
        end
    end

    assign CMD_FULL         = w_full;
    assign DONE_CNT         = r_done_cnt;
    assign BUSY             = (r_state != ST_IDLE) | ~w_empty;
    assign SDRAM_READ       = r_read;
    assign SDRAM_ADDRESS    = r_addr;
    assign SDRAM_BURSTCOUNT = r_bc;
    assign OUT_WR_EN        = r_out_wr_en;
    assign OUT_DATA         = r_out_data;

endmodule
